// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle for the PS/2 scan-code decoder.
// The mods bus exists only when PS2_MODIFIER_TRACK_EN is defined.
interface ps2_scancode_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_valid;
    logic       evt_ready;
    logic       ovf;
    logic       ovf_clr;
`ifdef PS2_MODIFIER_TRACK_EN
    logic [2:0] mods;
`endif

    modport master (
        input  rx_data, rx_valid, evt_ready, ovf_clr,
        output evt_code, evt_ext, evt_brk, evt_valid, ovf
`ifdef PS2_MODIFIER_TRACK_EN
        , output mods
`endif
    );

    modport slave (
        output rx_data, rx_valid, evt_ready, ovf_clr,
        input  evt_code, evt_ext, evt_brk, evt_valid, ovf
`ifdef PS2_MODIFIER_TRACK_EN
        , input mods
`endif
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 set-2 E0/F0 prefixes into key events and queues them in a small FIFO.
// Define PS2_MODIFIER_TRACK_EN to add the {alt, ctrl, shift} mods output.
module ps2_scancode_decoder #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 2500000
) (
    input  logic                          clk25,
    input  logic                          reset_n,
    ps2_scancode_decoder_if.master        bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    evt_t            mem_q [DEPTH];
    evt_t            mem_d [DEPTH];
    logic            ovf_q, ovf_d;

    logic            byte_ignored;
    logic            is_ext;
    logic            is_brk;
    logic            push;
    logic            pop;
    logic            push_ok;
    logic            full;
    logic            empty;
    evt_t            push_evt;
    evt_t            head;

    // Prefix FSM and timeout; reply/error bytes never touch state or the counter
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        push         = 1'b0;
        byte_ignored = bus.rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        is_ext       = (state_q == EXT) || (state_q == EXT_BRK);
        is_brk       = (state_q == BRK) || (state_q == EXT_BRK);
        push_evt     = '{ext: is_ext, brk: is_brk, code: bus.rx_data};

        if (state_q != IDLE) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (bus.rx_valid && !byte_ignored) begin
            cnt_d = '0;
            if (bus.rx_data == 8'hE0) begin
                state_d = is_brk ? EXT_BRK : EXT;
            end else if (bus.rx_data == 8'hF0) begin
                state_d = is_ext ? EXT_BRK : BRK;
            end else begin
                state_d = IDLE;
                push    = 1'b1;
            end
        end
    end

    // Event FIFO; a pop in the same cycle frees the slot for a push into a full FIFO
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
        pop     = !empty && bus.evt_ready;
        push_ok = push && (!full || pop);
        mem_d   = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = push_evt;
        end
        wr_d  = wr_q + PW'(push_ok);
        rd_d  = rd_q + PW'(pop);
        ovf_d = (ovf_q && !bus.ovf_clr) || (push && full && !pop);
        head  = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.evt_code  = head.code;
    assign bus.evt_ext   = head.ext;
    assign bus.evt_brk   = head.brk;
    assign bus.evt_valid = !empty;
    assign bus.ovf       = ovf_q;

`ifdef PS2_MODIFIER_TRACK_EN
    // side bits: {alt_r, alt_l, ctrl_r, ctrl_l, shift_r, shift_l}
    logic [5:0] side_q, side_d;
    logic [2:0] mods_q, mods_d;

    // Tracks make/break of each modifier side, even when the FIFO drops the event
    always_comb begin
        side_d = side_q;
        if (push) begin
            case ({push_evt.ext, push_evt.code})
                {1'b0, 8'h12}: side_d[0] = !push_evt.brk;
                {1'b0, 8'h59}: side_d[1] = !push_evt.brk;
                {1'b0, 8'h14}: side_d[2] = !push_evt.brk;
                {1'b1, 8'h14}: side_d[3] = !push_evt.brk;
                {1'b0, 8'h11}: side_d[4] = !push_evt.brk;
                {1'b1, 8'h11}: side_d[5] = !push_evt.brk;
                default:       side_d    = side_q;
            endcase
        end
        mods_d = {side_d[5] | side_d[4], side_d[3] | side_d[2], side_d[1] | side_d[0]};
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            side_q <= '0;
            mods_q <= '0;
        end else begin
            side_q <= side_d;
            mods_q <= mods_d;
        end
    end

    assign bus.mods = mods_q;
`endif
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events queued at stimulus, checked on pop.
module tb_ps2_scancode_decoder;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [9:0] exp_q [$];

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk25   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
        exp_q.push_back({ext, brk, code});
    endtask

    task automatic drain();
        bit done = 1'b0;
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.evt_valid) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
        check("empty_after_drain", 32'(bus.evt_valid), 32'd0);
        tick();
        bus.evt_ready = 1'b0;
    endtask

    // Scoreboard: every accepted pop must match the oldest expected event
    always @(negedge clk) begin
        if (reset_n && bus.evt_valid && bus.evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", {22'd0, bus.evt_ext, bus.evt_brk, bus.evt_code}, 32'h3FF);
            end else begin
                check("evt", {22'd0, bus.evt_ext, bus.evt_brk, bus.evt_code},
                      {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_ovf",   32'(bus.ovf),       32'd0);
        check("rst_code",  32'(bus.evt_code),  32'd0);
        check("rst_ext",   32'(bus.evt_ext),   32'd0);
        check("rst_brk",   32'(bus.evt_brk),   32'd0);
`ifdef PS2_MODIFIER_TRACK_EN
        check("rst_mods",  32'(bus.mods),      32'd0);
`endif
        reset_n = 1'b1;
        tick();

        // Plain make code and latency 1
        expect_evt(1'b0, 1'b0, 8'h1C);
        tick();
        bus.rx_data  = 8'h1C;
        bus.rx_valid = 1'b1;
        #2;
        check("lat_during_strobe", 32'(bus.evt_valid), 32'd0);
        tick();
        bus.rx_valid = 1'b0;
        check("lat_after_strobe", 32'(bus.evt_valid), 32'd1);
        drain();

        // Extended break and plain break
        expect_evt(1'b1, 1'b1, 8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'hF0); send(8'h1C);
        drain();

        // Overflow: DEPTH queued, one dropped
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            if (i < int'(DEPTH)) expect_evt(1'b0, 1'b0, 8'h21 + 8'(i));
            send(8'h21 + 8'(i));
        end
        check("ovf_set", 32'(bus.ovf), 32'd1);
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", 32'(bus.ovf), 32'd0);

        // Full FIFO, push and pop together: no overflow
        expect_evt(1'b0, 1'b0, 8'h2A);
        tick();
        bus.rx_data   = 8'h2A;
        bus.rx_valid  = 1'b1;
        bus.evt_ready = 1'b1;
        tick();
        bus.rx_valid  = 1'b0;
        bus.evt_ready = 1'b0;
        check("full_push_pop_ovf", 32'(bus.ovf), 32'd0);
        check("full_push_pop_valid", 32'(bus.evt_valid), 32'd1);
        drain();

        // Prefix timeout and ignored reply bytes, with evt_ready held high
        bus.evt_ready = 1'b1;
        send(8'hE0);
        repeat (TIMEOUT + 2) tick();
        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'h1C);
        send(8'hE0);
        repeat (TIMEOUT - 4) tick();
        expect_evt(1'b1, 1'b0, 8'h6B);
        send(8'h6B);
        expect_evt(1'b1, 1'b0, 8'h74);
        send(8'hE0); send(8'hFA); send(8'hAA); send(8'h74);
        drain();

        // Reset mid-sequence discards the pending prefix
        send(8'hE0); send(8'hF0);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_valid", 32'(bus.evt_valid), 32'd0);
        check("mid_rst_ovf",   32'(bus.ovf),       32'd0);
        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'h1C);
        drain();

`ifdef PS2_MODIFIER_TRACK_EN
        bus.evt_ready = 1'b1;
        expect_evt(1'b0, 1'b0, 8'h12); send(8'h12);
        expect_evt(1'b0, 1'b0, 8'h59); send(8'h59);
        check("mods_both_shift", 32'(bus.mods), 32'd1);
        expect_evt(1'b0, 1'b1, 8'h12); send(8'hF0); send(8'h12);
        check("mods_rshift_held", 32'(bus.mods), 32'd1);
        expect_evt(1'b0, 1'b1, 8'h59); send(8'hF0); send(8'h59);
        check("mods_shift_off", 32'(bus.mods), 32'd0);
        expect_evt(1'b1, 1'b0, 8'h14); send(8'hE0); send(8'h14);
        check("mods_rctrl", 32'(bus.mods), 32'd2);
        expect_evt(1'b1, 1'b0, 8'h11); send(8'hE0); send(8'h11);
        check("mods_ralt", 32'(bus.mods), 32'd6);
        expect_evt(1'b1, 1'b1, 8'h14); send(8'hE0); send(8'hF0); send(8'h14);
        expect_evt(1'b1, 1'b1, 8'h11); send(8'hE0); send(8'hF0); send(8'h11);
        check("mods_all_off", 32'(bus.mods), 32'd0);
        drain();
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
